// File: rtl/secure_pkg.sv
// Shared constants and types for the secure link: frame types, confirmation
// codes, framing bytes, frame geometry, CRC-32 parameters and the validator FSM
// state enum.
package secure_pkg;

  // Frame geometry (bytes)
  localparam int unsigned DataBytes     = 64;
  localparam int unsigned PreambleBytes = 7;
  localparam int unsigned CrcBytes      = 4;
  localparam int unsigned FrameBytes    = PreambleBytes + DataBytes + CrcBytes;

  // Frame type byte
  localparam logic [7:0] TypeFirst  = 8'h00;
  localparam logic [7:0] TypeLast   = 8'h01;
  localparam logic [7:0] TypeNormal = 8'h02;
  localparam logic [7:0] TypeSingle = 8'h03;

  // Confirmation codes returned to the PC
  localparam logic [7:0] CodeOkay  = 8'h05;
  localparam logic [7:0] CodeError = 8'h04;
  localparam logic [7:0] CodeFatal = 8'h08;

  // Control bytes of the upstream RS-232 framing layer
  localparam logic [7:0] FrameSof    = 8'h06;
  localparam logic [7:0] FrameEof    = 8'h07;
  localparam logic [7:0] FrameEsc    = 8'h14;
  localparam logic [7:0] FrameEscXor = 8'h20;

  // CRC-32/BZIP2
  localparam logic [31:0] CrcPoly = 32'h04C11DB7;
  localparam logic [31:0] CrcInit = 32'hFFFFFFFF;
  localparam logic [31:0] CrcXout = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StCrc,
    StCheck,
    StOutput,
    StConfirm
  } state_e;

  // Payload length field is usable only for 1..max bytes
  function automatic logic len_is_valid(input logic [15:0] len, input int unsigned max_len);
    return (len != 16'd0) && (len <= 16'(max_len));
  endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// One byte of a non-reflected CRC-32 (poly 0x04C11DB7), MSB first.
// Purely combinational.
module crc32_byte_step
  import secure_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_byte,
  output logic [31:0] crc_out
);

  logic [31:0] crc_work;

  // Eight shift/XOR steps with the byte pre-loaded into the top bits
  always_comb begin
    crc_work = crc_in ^ {data_byte, 24'h000000};
    for (int i = 0; i < 8; i++) begin
      if (crc_work[31]) begin
        crc_work = {crc_work[30:0], 1'b0} ^ CrcPoly;
      end else begin
        crc_work = {crc_work[30:0], 1'b0};
      end
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/frame_validator.sv
// Frame validator: checks CRC-32, length, type and (optionally) sequence
// number of a de-escaped frame, returns a confirmation code and forwards good
// payloads over valid/ready.
// Optional feature macro: FRAME_VALIDATOR_SEQ_CHECK_EN enables session and
// frame-number sequence checking.
module frame_validator
  import secure_pkg::*;
#(
  parameter int DATA_SIZE     = 64,
  parameter int PREAMBLE_SIZE = 7,
  parameter int CRC_SIZE      = 4,
  parameter int FRAME_SIZE    = (PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE) * 8 - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [0:FRAME_SIZE]    fin,
  input  logic                   fin_valid,
  output logic                   confirm,
  output logic [7:0]             conf_code,
  output logic [0:DATA_SIZE*8-1] dout,
  output logic [6:0]             dout_len,
  output logic                   dout_first,
  output logic                   dout_last,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   busy
);

  localparam int NBytes   = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE;
  localparam int IdxW     = $clog2(NBytes);
  localparam int CrcOff   = PREAMBLE_SIZE + DATA_SIZE;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(CrcOff - 1);

  state_e            state_q, state_d;
  logic [0:FRAME_SIZE] fin_q;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       crc_q, crc_d, crc_step;
  logic [7:0]        code_d;
  logic              fin_valid_q;
  logic              fin_valid_block_q;
  logic              start, load_out;

  // Header/trailer fields of the latched frame
  logic [7:0]  type_b, len_lo;
  logic [15:0] len_field;
  logic [31:0] crc_rx;
  logic        crc_ok, len_ok, type_ok, seq_ok;

  assign type_b    = fin_q[0 +: 8];
  assign len_lo    = fin_q[16 +: 8];
  assign len_field = {fin_q[8 +: 8], len_lo};
  assign crc_rx    = fin_q[CrcOff*8 +: 32];

  assign crc_ok  = ((crc_q ^ CrcXout) == crc_rx);
  assign len_ok  = len_is_valid(len_field, DATA_SIZE);
  assign type_ok = (type_b <= TypeSingle);

  crc32_byte_step u_crc_step (
    .crc_in    (crc_q),
    .data_byte (fin_q[int'(idx_q)*8 +: 8]),
    .crc_out   (crc_step)
  );

`ifdef FRAME_VALIDATOR_SEQ_CHECK_EN
  logic        active_q;
  logic [31:0] last_nr_q;
  logic [31:0] frame_nr;
  logic        upd_sess, clear_sess;

  assign frame_nr   = fin_q[24 +: 32];
  assign seq_ok     = (type_b == TypeFirst) || (type_b == TypeSingle) ||
                      (active_q && (frame_nr == last_nr_q + 32'd1));
  assign upd_sess   = (state_q == StOutput) && dout_ready;
  // Fatal errors (bad type or sequence) tear down the session
  assign clear_sess = (state_q == StCheck) && crc_ok && len_ok && (!type_ok || !seq_ok);

  // Session register: advances only on an accepted payload handshake
  always_ff @(posedge clk) begin
    if (rst || clear_sess) begin
      active_q  <= 1'b0;
      last_nr_q <= 32'd0;
    end else if (upd_sess) begin
      case (type_b)
        TypeFirst: begin
          active_q  <= 1'b1;
          last_nr_q <= frame_nr;
        end
        TypeSingle: active_q  <= 1'b0;
        TypeNormal: last_nr_q <= last_nr_q + 32'd1;
        default: begin
          active_q  <= 1'b0;
          last_nr_q <= last_nr_q + 32'd1;
        end
      endcase
    end
  end
`else
  assign seq_ok = 1'b1;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    crc_d    = crc_q;
    code_d   = conf_code;
    start    = 1'b0;
    load_out = 1'b0;
    case (state_q)
      StIdle: begin
        if (fin_valid && !fin_valid_q && !fin_valid_block_q) begin
          start   = 1'b1;
          idx_d   = '0;
          crc_d   = CrcInit;
          state_d = StCrc;
        end
      end
      StCrc: begin
        crc_d = crc_step;
        idx_d = idx_q + 1'b1;
        if (idx_q == IdxLast) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        state_d = StConfirm;
        if (!crc_ok || !len_ok) begin
          code_d = CodeError;
        end else if (!type_ok || !seq_ok) begin
          code_d = CodeFatal;
        end else begin
          load_out = 1'b1;
          state_d  = StOutput;
        end
      end
      StOutput: begin
        if (dout_ready) begin
          code_d  = CodeOkay;
          state_d = StConfirm;
        end
      end
      StConfirm: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State, CRC and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      idx_q             <= '0;
      crc_q             <= CrcInit;
      fin_valid_q       <= 1'b0;
      // A level still high across reset must fall before it can trigger
      fin_valid_block_q <= fin_valid;
      conf_code         <= 8'h00;
      dout              <= '0;
      dout_len          <= 7'd0;
      dout_first        <= 1'b0;
      dout_last         <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      crc_q       <= crc_d;
      conf_code   <= code_d;
      fin_valid_q <= fin_valid;
      if (!fin_valid) begin
        fin_valid_block_q <= 1'b0;
      end
      if (load_out) begin
        dout       <= fin_q[PREAMBLE_SIZE*8 +: DATA_SIZE*8];
        dout_len   <= len_lo[6:0];
        dout_first <= (type_b == TypeFirst) || (type_b == TypeSingle);
        dout_last  <= (type_b == TypeLast) || (type_b == TypeSingle);
      end
    end
  end

  // Frame capture; pure datapath, consumed only after a start
  always_ff @(posedge clk) begin
    if (start) begin
      fin_q <= fin;
    end
  end

  assign confirm    = (state_q == StConfirm);
  assign dout_valid = (state_q == StOutput);
  assign busy       = (state_q != StIdle);

endmodule
